// File: rtl/video_pkg.sv
// Shared constants and write-FSM state type for the double-buffered video frame store.
package video_pkg;

    localparam int PIXELS = 23040;
    localparam int ADDR_W = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } wr_state_t;

endpackage

// File: rtl/scanout_counter.sv
// Read-side address counter with frame wrap detection and one-cycle return pipe.
module scanout_counter #(
    parameter int PIXELS = video_pkg::PIXELS,
    parameter int ADDR_W = video_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rd_req,
    input  logic              front_sel,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              wrap,
    output logic              rd_valid,
    output logic              rd_first,
    output logic              rd_sel
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(PIXELS - 1);

    assign wrap = rd_req && (rd_addr == LAST);

    // rd_sel remembers which buffer the request went to, so a swap on the same edge cannot redirect the returning data
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_addr  <= '0;
            rd_valid <= 1'b0;
            rd_first <= 1'b0;
            rd_sel   <= 1'b0;
        end else begin
            rd_valid <= rd_req;
            rd_first <= rd_req && (rd_addr == '0);
            if (rd_req) begin
                rd_sel  <= front_sel;
                rd_addr <= wrap ? '0 : rd_addr + ADDR_W'(1);
            end
        end
    end

endmodule

// File: rtl/video_buffer_ctrl.sv
// Double-buffered frame store controller: PPU fills the back buffer while scanout reads the front one.
module video_buffer_ctrl #(
    parameter int PIXELS = video_pkg::PIXELS,
    parameter int ADDR_W = video_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              frame_start,
    input  logic              px_valid,
    input  logic [1:0]        px_data,
    input  logic              rd_req,
    output logic              rd_valid,
    output logic [1:0]        rd_data,
    output logic              rd_first,
    output logic [ADDR_W-1:0] buf0_addra,
    output logic [1:0]        buf0_dina,
    output logic              buf0_wea,
    output logic              buf0_ena,
    output logic [ADDR_W-1:0] buf0_addrb,
    output logic              buf0_enb,
    input  logic [1:0]        buf0_doutb,
    output logic [ADDR_W-1:0] buf1_addra,
    output logic [1:0]        buf1_dina,
    output logic              buf1_wea,
    output logic              buf1_ena,
    output logic [ADDR_W-1:0] buf1_addrb,
    output logic              buf1_enb,
    input  logic [1:0]        buf1_doutb,
    output logic              front_sel,
    output logic              frame_repeat
);

    import video_pkg::*;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(PIXELS - 1);

    wr_state_t         state;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] wr_port_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic              wr_en;
    logic              rd_go;
    logic              wrap;
    logic              rd_sel;
    logic              fill_done;
    logic              swap;

    // A frame_start pixel lands at address 0 even when coming from IDLE or DONE
    assign wr_en        = reset_n && px_valid && (frame_start || state == FILL);
    assign wr_port_addr = frame_start ? '0 : wr_addr;
    assign rd_go        = reset_n && rd_req;
    assign fill_done    = (state == FILL) && px_valid && !frame_start && (wr_addr == LAST);
    // A restarting writer holds no finished frame, so a coincident wrap repeats instead
    assign swap         = wrap && !frame_start && (state == DONE || fill_done);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            wr_addr <= '0;
        end else if (frame_start) begin
            state   <= FILL;
            wr_addr <= px_valid ? ADDR_W'(1) : '0;
        end else begin
            case (state)
                FILL: begin
                    if (px_valid) begin
                        if (wr_addr == LAST) begin
                            wr_addr <= '0;
                            state   <= swap ? IDLE : DONE;
                        end else begin
                            wr_addr <= wr_addr + ADDR_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (swap) state <= IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            front_sel    <= 1'b0;
            frame_repeat <= 1'b0;
        end else begin
            frame_repeat <= wrap && !swap;
            if (swap) front_sel <= !front_sel;
        end
    end

    scanout_counter #(
        .PIXELS (PIXELS),
        .ADDR_W (ADDR_W)
    ) u_scanout (
        .clk       (clk),
        .reset_n   (reset_n),
        .rd_req    (rd_go),
        .front_sel (front_sel),
        .rd_addr   (rd_addr),
        .wrap      (wrap),
        .rd_valid  (rd_valid),
        .rd_first  (rd_first),
        .rd_sel    (rd_sel)
    );

    assign buf0_ena   = wr_en && front_sel;
    assign buf0_wea   = wr_en && front_sel;
    assign buf1_ena   = wr_en && !front_sel;
    assign buf1_wea   = wr_en && !front_sel;
    assign buf0_addra = wr_port_addr;
    assign buf1_addra = wr_port_addr;
    assign buf0_dina  = px_data;
    assign buf1_dina  = px_data;

    assign buf0_enb   = rd_go && !front_sel;
    assign buf1_enb   = rd_go && front_sel;
    assign buf0_addrb = rd_addr;
    assign buf1_addrb = rd_addr;

    assign rd_data    = rd_sel ? buf1_doutb : buf0_doutb;

endmodule

// File: tb/tb_video_buffer_ctrl.sv
// Directed bench for video_buffer_ctrl: vector table for short sequences, hand sequences for full-frame corners.
module tb_video_buffer_ctrl;

    localparam int PIXELS = 23040;
    localparam int ADDR_W = 15;

    logic              clk;
    logic              reset_n;
    logic              frame_start;
    logic              px_valid;
    logic [1:0]        px_data;
    logic              rd_req;
    logic              rd_valid;
    logic [1:0]        rd_data;
    logic              rd_first;
    logic [ADDR_W-1:0] buf0_addra, buf1_addra, buf0_addrb, buf1_addrb;
    logic [1:0]        buf0_dina, buf1_dina, buf0_doutb, buf1_doutb;
    logic              buf0_wea, buf0_ena, buf0_enb, buf1_wea, buf1_ena, buf1_enb;
    logic              front_sel;
    logic              frame_repeat;

    int vectors = 0;
    int fails   = 0;

    video_buffer_ctrl #(.PIXELS(PIXELS), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .frame_start  (frame_start),
        .px_valid     (px_valid),
        .px_data      (px_data),
        .rd_req       (rd_req),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .rd_first     (rd_first),
        .buf0_addra   (buf0_addra),
        .buf0_dina    (buf0_dina),
        .buf0_wea     (buf0_wea),
        .buf0_ena     (buf0_ena),
        .buf0_addrb   (buf0_addrb),
        .buf0_enb     (buf0_enb),
        .buf0_doutb   (buf0_doutb),
        .buf1_addra   (buf1_addra),
        .buf1_dina    (buf1_dina),
        .buf1_wea     (buf1_wea),
        .buf1_ena     (buf1_ena),
        .buf1_addrb   (buf1_addrb),
        .buf1_enb     (buf1_enb),
        .buf1_doutb   (buf1_doutb),
        .front_sel    (front_sel),
        .frame_repeat (frame_repeat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Preloaded buffer 0 pattern and the pattern the writer streams into buffer 1
    function automatic logic [1:0] q0(input int i);
        return 2'((i + 1 + (i >> 2)) & 3);
    endfunction

    function automatic logic [1:0] pat(input int i);
        return 2'((i ^ (i >> 3) ^ 2) & 3);
    endfunction

    // Two simple dual-port RAMs with one cycle of read latency; buffer 0 is seeded on the first edge
    logic [1:0] mem0 [PIXELS];
    logic [1:0] mem1 [PIXELS];
    logic       preloaded = 1'b0;

    always @(posedge clk) begin
        if (!preloaded) begin
            for (int k = 0; k < PIXELS; k++) begin
                mem0[k] <= q0(k);
                mem1[k] <= 2'b00;
            end
            preloaded <= 1'b1;
        end else begin
            if (buf0_ena && buf0_wea) mem0[buf0_addra] <= buf0_dina;
            if (buf1_ena && buf1_wea) mem1[buf1_addra] <= buf1_dina;
        end
        if (buf0_enb) buf0_doutb <= mem0[buf0_addrb];
        if (buf1_enb) buf1_doutb <= mem1[buf1_addrb];
    end

    initial begin
        #1200000;
        $display("[TB] FAIL watchdog: sim time %0t reached, required completion earlier", $time);
        $fatal(1, "[TB] timeout");
    end

    task automatic applyStimulus(input logic fs, input logic pv, input logic [1:0] d, input logic rq);
        frame_start = fs;
        px_valid    = pv;
        px_data     = d;
        rd_req      = rq;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    typedef struct packed {
        logic              fs;
        logic              pv;
        logic [1:0]        d;
        logic              rq;
        logic              ena1;
        logic              ena0;
        logic [ADDR_W-1:0] addra;
        logic              enb0;
        logic [ADDR_W-1:0] addrb;
        logic              rvalid;
        logic              rfirst;
        logic [1:0]        rdata;
    } vec_t;

    vec_t tbl [7];

    initial begin
        int wcount, abad, b0bad, membad, rbad, dbad, rep, fsbad, vcount;

        tbl[0] = '{1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 15'd0, 1'b0, 15'd0, 1'b0, 1'b0, 2'd0};
        tbl[1] = '{1'b1, 1'b1, 2'd3, 1'b0, 1'b1, 1'b0, 15'd0, 1'b0, 15'd0, 1'b0, 1'b0, 2'd0};
        tbl[2] = '{1'b0, 1'b1, 2'd2, 1'b1, 1'b1, 1'b0, 15'd1, 1'b1, 15'd0, 1'b0, 1'b0, 2'd0};
        tbl[3] = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 15'd2, 1'b1, 15'd1, 1'b1, 1'b1, q0(0)};
        tbl[4] = '{1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 15'd2, 1'b0, 15'd2, 1'b1, 1'b0, q0(1)};
        tbl[5] = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 15'd0, 1'b0, 15'd2, 1'b0, 1'b0, 2'd0};
        tbl[6] = '{1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 15'd0, 1'b0, 15'd2, 1'b0, 1'b0, 2'd0};

        // Reset with active inputs: nothing may reach the RAM ports
        reset_n = 1'b0;
        applyStimulus(1'b1, 1'b1, 2'd3, 1'b1);
        repeat (3) @(posedge clk);
        #2;
        checkOutput("reset_port_enables", 32'({buf0_ena, buf0_wea, buf1_ena, buf1_wea, buf0_enb, buf1_enb}), 32'd0);
        checkOutput("reset_regs", 32'({rd_valid, rd_first, frame_repeat, front_sel}), 32'd0);
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b0);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            applyStimulus(tbl[i].fs, tbl[i].pv, tbl[i].d, tbl[i].rq);
            #2;
            checkOutput($sformatf("vec%0d_wen", i), 32'({buf1_ena, buf1_wea, buf0_ena, buf0_wea}),
                        32'({tbl[i].ena1, tbl[i].ena1, tbl[i].ena0, tbl[i].ena0}));
            checkOutput($sformatf("vec%0d_addra", i), 32'(buf1_addra), 32'(tbl[i].addra));
            checkOutput($sformatf("vec%0d_dina", i), 32'(buf1_dina), 32'(tbl[i].d));
            checkOutput($sformatf("vec%0d_ren", i), 32'({buf0_enb, buf1_enb}), 32'({tbl[i].enb0, 1'b0}));
            checkOutput($sformatf("vec%0d_addrb", i), 32'(buf0_addrb), 32'(tbl[i].addrb));
            checkOutput($sformatf("vec%0d_rvalid_first", i), 32'({rd_valid, rd_first}),
                        32'({tbl[i].rvalid, tbl[i].rfirst}));
            if (tbl[i].rvalid) checkOutput($sformatf("vec%0d_rdata", i), 32'(rd_data), 32'(tbl[i].rdata));
            tick();
        end

        // Reset while filling, then a stray pixel must be ignored in IDLE
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b0);
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
        tick();
        applyStimulus(1'b0, 1'b1, 2'd1, 1'b0);
        #2;
        checkOutput("idle_px_ignored", 32'({buf0_ena, buf1_ena}), 32'd0);
        tick();

        // Full frame into buffer 1, first pixel coinciding with frame_start
        wcount = 0; abad = 0; b0bad = 0;
        for (int i = 0; i < PIXELS; i++) begin
            applyStimulus(i == 0, 1'b1, pat(i), 1'b0);
            #2;
            if (buf1_ena && buf1_wea) wcount++;
            if (buf1_addra !== 15'(i)) abad++;
            if (buf0_ena || buf0_wea) b0bad++;
            tick();
        end
        applyStimulus(1'b0, 1'b1, 2'd3, 1'b0);
        #2;
        checkOutput("px_after_done_ignored", 32'({buf0_ena, buf1_ena}), 32'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b0);
        checkOutput("fill_write_count", 32'(wcount), 32'(PIXELS));
        checkOutput("fill_addr_seq", 32'(abad), 32'd0);
        checkOutput("fill_buf0_untouched", 32'(b0bad), 32'd0);
        membad = 0;
        for (int i = 0; i < PIXELS; i++) if (mem1[i] !== pat(i)) membad++;
        checkOutput("buf1_contents", 32'(membad), 32'd0);

        // Back-to-back scan of buffer 0 with the writer DONE: swap right after the last request
        rbad = 0; dbad = 0; rep = 0; fsbad = 0;
        for (int i = 0; i < PIXELS; i++) begin
            applyStimulus(1'b0, 1'b0, 2'd0, 1'b1);
            #2;
            if (!(buf0_enb && !buf1_enb && buf0_addrb == 15'(i))) rbad++;
            tick();
            if (rd_valid !== 1'b1 || rd_data !== q0(i) || rd_first !== (i == 0)) dbad++;
            if (frame_repeat) rep++;
            if (i < PIXELS - 1 && front_sel !== 1'b0) fsbad++;
        end
        checkOutput("scan0_read_port", 32'(rbad), 32'd0);
        checkOutput("scan0_data_latency", 32'(dbad), 32'd0);
        checkOutput("scan0_no_repeat", 32'(rep), 32'd0);
        checkOutput("scan0_front_hold", 32'(fsbad), 32'd0);
        checkOutput("swap_front_sel", 32'(front_sel), 32'd1);
        #2;
        checkOutput("swap_buf1_read_port", 32'({buf1_enb, buf0_enb}), 32'b10);
        checkOutput("swap_buf1_addr", 32'(buf1_addrb), 32'd0);
        tick();
        checkOutput("swap_first_pixel", 32'({rd_valid, rd_first, rd_data}), 32'({1'b1, 1'b1, pat(0)}));
        applyStimulus(1'b0, 1'b1, 2'd2, 1'b0);
        #2;
        checkOutput("after_swap_idle_px", 32'({buf0_ena, buf1_ena}), 32'd0);
        tick();

        // Writer only 100 pixels into buffer 0 when the reader wraps: repeat the frame
        wcount = 0; b0bad = 0;
        for (int i = 0; i < 100; i++) begin
            applyStimulus(i == 0, 1'b1, pat(i), 1'b0);
            #2;
            if (buf0_ena && buf0_wea) wcount++;
            if (buf1_ena) b0bad++;
            tick();
        end
        checkOutput("fill0_write_count", 32'(wcount), 32'd100);
        checkOutput("fill0_buf1_untouched", 32'(b0bad), 32'd0);
        rep = 0;
        for (int i = 1; i < PIXELS; i++) begin
            applyStimulus(1'b0, 1'b0, 2'd0, 1'b1);
            tick();
            if (frame_repeat) rep++;
        end
        checkOutput("frame_repeat_pulse", 32'(frame_repeat), 32'd1);
        checkOutput("frame_repeat_count", 32'(rep), 32'd1);
        checkOutput("repeat_front_hold", 32'(front_sel), 32'd1);
        #2;
        checkOutput("repeat_rd_addr_wrap", 32'({buf1_enb, buf1_addrb}), 32'({1'b1, 15'd0}));
        tick();
        checkOutput("frame_repeat_one_cycle", 32'(frame_repeat), 32'd0);
        checkOutput("repeat_first_pixel", 32'({rd_valid, rd_first, rd_data}), 32'({1'b1, 1'b1, pat(0)}));

        // Restart at wr_addr 5000 with a coincident pixel
        for (int i = 100; i < 5000; i++) begin
            applyStimulus(1'b0, 1'b1, pat(i), 1'b0);
            tick();
        end
        applyStimulus(1'b1, 1'b1, 2'b11, 1'b0);
        #2;
        checkOutput("restart_wen", 32'({buf0_ena, buf0_wea, buf1_ena}), 32'b110);
        checkOutput("restart_addr_data", 32'({buf0_addra, buf0_dina}), 32'({15'd0, 2'b11}));
        tick();
        applyStimulus(1'b0, 1'b1, 2'd1, 1'b0);
        #2;
        checkOutput("restart_next_addr", 32'({buf0_ena, buf0_addra}), 32'({1'b1, 15'd1}));
        tick();
        checkOutput("restart_mem0_addr0", 32'(mem0[0]), 32'd3);

        // Reset mid-frame at wr_addr 12000 with reads in flight
        for (int i = 2; i < 12000; i++) begin
            applyStimulus(1'b0, 1'b1, pat(i), i >= 11990);
            tick();
        end
        checkOutput("inflight_before_reset", 32'(rd_valid), 32'd1);
        applyStimulus(1'b0, 1'b1, 2'd1, 1'b1);
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("midreset_regs", 32'({rd_valid, rd_first, frame_repeat, front_sel}), 32'd0);
        checkOutput("midreset_enables", 32'({buf0_ena, buf0_wea, buf1_ena, buf1_wea, buf0_enb, buf1_enb}), 32'd0);
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
        vcount = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (rd_valid) vcount++;
        end
        checkOutput("no_spurious_rd_valid", 32'(vcount), 32'd0);
        applyStimulus(1'b0, 1'b1, 2'd2, 1'b1);
        #2;
        checkOutput("post_reset_ports", 32'({buf0_ena, buf1_ena, buf0_enb, buf1_enb, buf0_addrb}),
                    32'({1'b0, 1'b0, 1'b1, 1'b0, 15'd0}));
        tick();
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b0);
        checkOutput("post_reset_read", 32'({rd_valid, rd_first, rd_data}), 32'({1'b1, 1'b1, mem0[0]}));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/video_buffer_ctrl.md
VIDEO_BUFFER_CTRL -- requirements
Module: video_buffer_ctrl

Interface
REQ-001 Parameter PIXELS, default 23040, SHALL set pixels per frame (160x144).
REQ-002 Parameter ADDR_W, default 15, SHALL set the buffer address width.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  in  1  SHALL be the single clock; all logic samples on its rising edge.
REQ-005 reset_n  in  1  SHALL be the asynchronous active-low reset.
REQ-006 frame_start  in  1  SHALL be a one-cycle PPU pulse marking the start of a new frame.
REQ-007 px_valid, px_data  in  1, 2  SHALL carry the pixel write strobe and the 2-bit shade.
REQ-008 rd_req  in  1  SHALL request the next scanout pixel.
REQ-009 rd_valid, rd_data, rd_first  out  1, 2, 1  SHALL carry the returned pixel; rd_first flags pixel 0 of a frame.
REQ-010 bufN_addra, bufN_dina, bufN_wea, bufN_ena  out  ADDR_W, 2, 1, 1  SHALL drive the write port of buffer N (N = 0, 1).
REQ-011 bufN_addrb, bufN_enb  out  ADDR_W, 1  SHALL drive the read port of buffer N; bufN_doutb  in  2  SHALL be its read data.
REQ-012 front_sel  out  1  SHALL indicate which buffer is being scanned out; frame_repeat  out  1  SHALL pulse when a frame is re-scanned.

Function
REQ-013 The write side SHALL always target the back buffer (!front_sel); the read side SHALL always target the front buffer.
REQ-014 The write FSM SHALL have states IDLE, FILL and DONE.
REQ-015 IDLE->FILL on frame_start; FILL->DONE when the pixel at address PIXELS-1 is written; DONE->IDLE on a buffer swap.
REQ-016 In FILL, each px_valid SHALL write px_data at wr_addr to the back buffer (ena=wea=1 that cycle) and increment wr_addr.
REQ-017 px_valid in IDLE or DONE SHALL be ignored: no write-port enable.
REQ-018 frame_start in FILL or DONE SHALL restart the fill at address 0 in FILL; any partial frame is abandoned.
REQ-019 If frame_start and px_valid coincide, the pixel SHALL be written to address 0 of the new frame and wr_addr SHALL become 1.
REQ-020 Each rd_req SHALL assert enb with rd_addr on the front buffer and increment rd_addr.
REQ-021 rd_addr SHALL wrap from PIXELS-1 to 0.
REQ-022 rd_valid/rd_data SHALL follow the accepted rd_req with fixed latency 1 cycle: RAM latency 1, with doutb routed combinationally by a registered select.
REQ-023 When the request at rd_addr PIXELS-1 is accepted and the write FSM is DONE (or enters DONE in the same cycle), front_sel SHALL toggle on the next edge and the write FSM SHALL go to IDLE.
REQ-024 If the write FSM is not DONE at that wrap, front_sel SHALL hold and frame_repeat SHALL pulse for one cycle.
REQ-025 rd_first SHALL accompany the data returned for rd_addr 0.
REQ-026 The write and read port signals of each buffer SHALL never both target the same buffer in one cycle.
REQ-027 In-flight read data SHALL use the buffer select registered at request time, so a swap cannot corrupt it.

Reset
REQ-028 Reset SHALL set: FSM=IDLE, wr_addr=0, rd_addr=0, front_sel=0, rd_valid=0, rd_first=0, frame_repeat=0, and all ena/wea/enb=0.
REQ-029 Reset asserted mid-frame SHALL discard all in-flight reads; no rd_valid SHALL appear after release until a new rd_req.

Structure
REQ-030 PIXELS, ADDR_W and the write-FSM state enum SHALL live in a shared package, video_pkg.
REQ-031 The read-side address counter, wrap detection and latency pipe SHALL be a sub-module, scanout_counter.

Verification
REQ-032 Directed scenario: reset, then frame_start plus 23040 px_valid -> buf1 written at addr 0..23039; state DONE; 23041st px ignored.
REQ-033 Directed scenario: 23040 rd_req with DONE -> rd_data from buf0, then front_sel=1 one cycle after the last request; next read comes from buf1 with rd_first=1.
REQ-034 Directed scenario: reader wraps while writer is at pixel 100 -> frame_repeat=1 for 1 cycle, front_sel unchanged, rd_addr=0.
REQ-035 Directed scenario: frame_start at wr_addr 5000 coinciding with px_valid data 2'b11 -> buf write at addr 0 = 3, wr_addr=1.
REQ-036 Directed scenario: back-to-back rd_req every cycle -> rd_valid continuous, latency exactly 1, data matches a model.
REQ-037 Directed scenario: reset_n low at wr_addr 12000 with reads in flight -> all outputs at reset values, no spurious rd_valid.
